// File: rtl/led_sched_pkg.sv
// Shared types and width constants for the LED pulse scheduler.
// The state encoding is fixed so that it reads the same in waveforms across the codebase.
package led_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int COUNT_W = 4;
  localparam int LEVEL_W = 3;
  localparam int PWM_W   = 3;

  // The phase counter only has to reach (longest window - 1).
  function automatic int phase_w(input int on_t, input int off_t, input int gap_t);
    int m;
    m = on_t;
    if (off_t > m) m = off_t;
    if (gap_t > m) m = gap_t;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/led_pulse_sched_tick_gen.sv
// Free-running prescaler. o_tick is high for one clk while the count sits at
// TICK_DIV-1, which is the cycle on which the count wraps back to 0.
module tick_gen #(
  parameter int TICK_DIV = 240
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int CW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + 1'b1;
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/led_pulse_sched.sv
// Round-robin scheduler that shares one active-low LED between NREQ requesters.
// Each grant plays count ON/OFF blink pairs at a PWM level, then a dark guard gap.
module led_pulse_sched
  import led_sched_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int TICK_DIV  = 240,
  parameter int ON_TICKS  = 15000,
  parameter int OFF_TICKS = 15000,
  parameter int GAP_TICKS = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [COUNT_W*NREQ-1:0] req_count,
  input  logic [LEVEL_W*NREQ-1:0] req_level,
  output logic [NREQ-1:0]         req_ack,
  output logic                    busy,
  output logic [1:0]              grant_id,
  output logic                    led_n
);

  localparam int PH_W = phase_w(ON_TICKS, OFF_TICKS, GAP_TICKS);
  localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_TICKS - 1);
  localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_TICKS - 1);
  localparam logic [1:0]      REQ_LAST = 2'(NREQ - 1);

  state_t               r_state, w_state_nxt;
  logic                 w_tick;
  logic                 w_exit;
  logic [PH_W-1:0]      r_phase;
  logic [PWM_W-1:0]     r_pwm;
  logic [COUNT_W-1:0]   r_remaining;
  logic [LEVEL_W-1:0]   r_level;
  logic [1:0]           r_rr;
  logic [1:0]           r_grant;
  logic [NREQ-1:0]      r_ack;
  logic                 r_led_n;
  logic                 w_found;
  logic [1:0]           w_win;
  logic [COUNT_W-1:0]   w_cnt_sel;
  logic [LEVEL_W-1:0]   w_lvl_sel;
  logic                 w_lit;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .o_tick (w_tick)
  );

  // First pass covers requesters at or above rr_ptr, second pass wraps to the bottom.
  always_comb begin
    w_found   = 1'b0;
    w_win     = '0;
    w_cnt_sel = '0;
    w_lvl_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req_valid[i] && (2'(i) >= r_rr)) begin
        w_found = 1'b1;
        w_win   = 2'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req_valid[i]) begin
        w_found = 1'b1;
        w_win   = 2'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == 2'(i)) begin
        w_cnt_sel = req_count[i*COUNT_W +: COUNT_W];
        w_lvl_sel = req_level[i*LEVEL_W +: LEVEL_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_exit      = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_found) w_state_nxt = (w_cnt_sel != '0) ? ST_ON : ST_GAP;
      ST_ON: begin
        w_exit = w_tick && (r_phase == ON_LAST);
        if (w_exit) w_state_nxt = ST_OFF;
      end
      ST_OFF: begin
        w_exit = w_tick && (r_phase == OFF_LAST);
        if (w_exit) w_state_nxt = (r_remaining != '0) ? ST_ON : ST_GAP;
      end
      ST_GAP: begin
        w_exit = w_tick && (r_phase == GAP_LAST);
        if (w_exit) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_lit = (r_state == ST_ON) && (r_pwm < r_level);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase     <= '0;
      r_pwm       <= '0;
      r_remaining <= '0;
      r_level     <= '0;
      r_rr        <= '0;
      r_grant     <= '0;
      r_ack       <= '0;
      r_led_n     <= 1'b1;
    end else begin
      r_ack   <= '0;
      r_led_n <= ~w_lit;
      if (w_tick) r_pwm <= r_pwm + 1'b1;
      // Phase restarts on every state change; IDLE never leaves it non-zero.
      if (w_state_nxt != r_state)              r_phase <= '0;
      else if (w_tick && r_state != ST_IDLE)   r_phase <= r_phase + 1'b1;
      if (r_state == ST_IDLE && w_found) begin
        r_remaining <= w_cnt_sel;
        r_level     <= w_lvl_sel;
        r_grant     <= w_win;
        r_ack       <= NREQ'(1) << w_win;
        r_rr        <= (w_win == REQ_LAST) ? 2'd0 : w_win + 2'd1;
      end else if (r_state == ST_ON && w_exit) begin
        r_remaining <= r_remaining - 1'b1;
      end
    end
  end

  assign req_ack  = r_ack;
  assign busy     = (r_state != ST_IDLE);
  assign grant_id = r_grant;
  assign led_n    = r_led_n;

endmodule

// File: tb/tb_led_pulse_sched.sv
// Randomized bench for led_pulse_sched against a window-queue reference model.
module tb_led_pulse_sched;

  localparam int NREQ = 3, DIV = 4, ONT = 3, OFFT = 2, GAPT = 5;
  localparam int K_ON = 0, K_OFF = 1, K_GAP = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [4*NREQ-1:0]    req_count;
  logic [3*NREQ-1:0]    req_level;
  logic [NREQ-1:0]      req_ack;
  logic                 busy;
  logic [1:0]           grant_id;
  logic                 led_n;

  led_pulse_sched #(
    .NREQ(NREQ), .TICK_DIV(DIV), .ON_TICKS(ONT), .OFF_TICKS(OFFT), .GAP_TICKS(GAPT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_count (req_count),
    .req_level (req_level),
    .req_ack   (req_ack),
    .busy      (busy),
    .grant_id  (grant_id),
    .led_n     (led_n)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a burst is a queue of (window kind, ticks left) entries.
  typedef struct { int kind; int left; } win_t;
  win_t            m_q[$];
  int              m_cyc, m_pwm, m_rr, m_lvl, m_grant;
  logic            m_led_n;
  logic [NREQ-1:0] m_ack;
  int              mode;   // 0 drop on ack, 1 hold, 2 random

  function automatic void model_reset();
    m_q.delete();
    m_cyc = 0; m_pwm = 0; m_rr = 0; m_lvl = 0; m_grant = 0;
    m_led_n = 1'b1; m_ack = '0;
  endfunction

  function automatic void push_win(input int kind, input int len);
    win_t w;
    w.kind = kind; w.left = len;
    m_q.push_back(w);
  endfunction

  function automatic void model_step();
    bit   tick;
    logic nl;
    int   w, n;
    tick = ((m_cyc % DIV) == DIV - 1);
    nl = 1'b1;
    if (m_q.size() > 0 && m_q[0].kind == K_ON && m_pwm < m_lvl) nl = 1'b0;
    m_ack = '0;
    if (m_q.size() == 0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_rr + k) % NREQ;
        if (w < 0 && ((req_valid >> idx) & 1'b1) != 0) w = idx;
      end
      if (w >= 0) begin
        n       = int'((req_count >> (4 * w)) & 12'hF);
        m_lvl   = int'((req_level >> (3 * w)) & 9'h7);
        m_ack   = NREQ'(1) << w;
        m_grant = w;
        m_rr    = (w + 1) % NREQ;
        for (int b = 0; b < n; b++) begin
          push_win(K_ON, ONT);
          push_win(K_OFF, OFFT);
        end
        push_win(K_GAP, GAPT);
      end
    end else if (tick) begin
      if (m_q[0].left == 1) void'(m_q.pop_front());
      else m_q[0].left = m_q[0].left - 1;
    end
    if (tick) m_pwm = (m_pwm + 1) % 8;
    m_cyc++;
    m_led_n = nl;
  endfunction

  task automatic set_req(input int i, input int cnt, input int lvl);
    logic [3:0] c;
    logic [2:0] l;
    c = cnt[3:0];
    l = lvl[2:0];
    req_count[4*i +: 4] = c;
    req_level[3*i +: 3] = l;
    req_valid[i] = 1'b1;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (m_ack[i]) begin
        if (mode == 0 || (mode == 2 && $urandom_range(0, 2) != 0)) req_valid[i] = 1'b0;
      end
      if (mode == 2) begin
        if (!req_valid[i] && $urandom_range(0, 39) == 0)
          set_req(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
        else if ($urandom_range(0, 15) == 0) begin
          req_count[4*i +: 4] = 4'($urandom_range(0, 3));
          req_level[3*i +: 3] = 3'($urandom_range(0, 7));
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("led_n", 32'(led_n), 32'(m_led_n));
    chk("busy", 32'(busy), 32'(m_q.size() != 0));
    chk("req_ack", 32'(req_ack), 32'(m_ack));
    chk("grant_id", 32'(grant_id), 32'(m_grant));
  endtask

  task automatic run(input int n);
    repeat (n) begin
      cyc();
      drive();
    end
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (m_q.size() != 0 && k < bound) begin
      run(1);
      k++;
    end
    chk("idle_timeout", 32'(m_q.size() == 0), 32'd1);
  endtask

  initial begin
    bit got;
    reset = 1'b1;
    req_valid = '0; req_count = '0; req_level = '0;
    mode = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_led_n", 32'(led_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(req_ack), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    reset = 1'b0;

    run(100);                          // quiet period
    set_req(1, 2, 7);  run(120);       // single 2-blink burst
    mode = 1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 5);
    run(180);                          // contention, round-robin order
    req_valid = '0; mode = 0;
    wait_idle(200);
    set_req(2, 0, 7);  run(40);        // zero-count request
    set_req(0, 3, 0);  run(100);       // level 0: dark but same timing
    set_req(1, 3, 7);  run(100);       // level 7 reference length
    mode = 2;          run(2500);
    mode = 0; req_valid = '0;
    wait_idle(400);

    // Reset in the middle of the second ON window of a 3-blink burst.
    mode = 1;
    set_req(0, 3, 7);
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      cyc();
      if (m_ack[0]) got = 1'b1;
    end
    chk("ack_timeout", 32'(got), 32'd1);
    set_req(2, 1, 7);
    run(26);
    chk("mid_busy", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_led_n", 32'(led_n), 32'd1);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_ack", 32'(req_ack), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run(150);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
